braille_sequencer: RTL
======================

BRAILLE_SEQUENCER -- requirements
Module: braille_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 50000, clock cycles each Braille cell is displayed; legal range 1..65535.
REQ-002 Parameter GAP_CYCLES, default 10000, blank cycles between cells; legal range 0..65535, where 0 means no gap.
REQ-003 Parameter DEPTH, fixed at 4, number of character buffer entries.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  upstream presents a character.
REQ-007 in_ready  out  1  buffer can accept a character.
REQ-008 in_char  in  8  ASCII byte.
REQ-009 pause  in  1  freezes the display timing while high.
REQ-010 dec_bits  out  6  to decoder inputs c,d,e,f,g,h (bit5=c .. bit0=h).
REQ-011 dec_en  out  1  current cell is valid and shown (LED enable).
REQ-012 char_done  out  1  one-cycle pulse when a cell's hold time completes.
REQ-013 busy  out  1  high in any state other than IDLE, or when the buffer is non-empty.
REQ-014 fifo_count  out  3  buffer occupancy, 0..4.
REQ-015 err  out  1  sticky flag: a non-ASCII byte (in_char[7]=1) was received.

Function
REQ-016 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL equal (fifo_count<4), derived from registered state only.
REQ-017 A transferred byte with in_char[7]=0 SHALL be written to the FIFO with bits [5:0] stored; a byte with in_char[7]=1 SHALL be consumed, not stored, and SHALL set err.
REQ-018 The FIFO SHALL be first-in first-out with wrap-around pointers; a same-cycle push and pop SHALL leave fifo_count unchanged; a push while full SHALL not occur because in_ready=0.
REQ-019 The FSM SHALL have states IDLE, SHOW and GAP.
REQ-020 IDLE: if fifo_count>0, the block SHALL pop the head entry into dec_bits and enter SHOW on the next edge; otherwise it SHALL stay in IDLE.
REQ-021 SHOW: dec_en=1 and dec_bits SHALL be held constant; the hold counter SHALL advance once per cycle while pause=0; after exactly HOLD_CYCLES advancing cycles the block SHALL pulse char_done and leave SHOW.
REQ-022 On leaving SHOW, the next state SHALL be GAP if GAP_CYCLES>0; otherwise it SHALL be SHOW with an immediate pop if fifo_count>0, else IDLE.
REQ-023 GAP: dec_en=0 and dec_bits=0; the counter SHALL advance while pause=0; after GAP_CYCLES advancing cycles the block SHALL pop and enter SHOW if fifo_count>0, else enter IDLE.
REQ-024 In IDLE, dec_en=0 and dec_bits=0.
REQ-025 Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE SHALL produce dec_en=1 with its bits after edge N+2.
REQ-026 pause SHALL freeze only the timers; the FIFO SHALL keep accepting input, and a pause asserted in IDLE SHALL not block the pop.
REQ-027 The counters SHALL be 16 bits and cleared on every state entry; no overflow SHALL be possible within the legal range.
REQ-028 err SHALL remain set until reset.

Reset
REQ-029 While rst_n=0, regardless of clk: state=IDLE, FIFO empty, fifo_count=0, in_ready=1, dec_bits=0, dec_en=0, char_done=0, busy=0, err=0, counters=0.
REQ-030 Reset asserted mid-SHOW or mid-GAP SHALL discard the displayed and buffered characters; operation SHALL resume normally on the first edge after release.

Verification
REQ-031 HOLD=3, GAP=2; send 'A' (0x41) into the empty FIFO -> dec_bits=6'b000001 with dec_en=1 for exactly 3 cycles starting 2 edges after the accept, char_done pulses once, 2 blank cycles, then IDLE with busy=0.
REQ-032 Push 5 bytes back-to-back with in_valid held high -> fifo_count reaches 4 and in_ready drops; the 5th byte is accepted only after the first pop; all 5 cells are displayed in input order.
REQ-033 HOLD=4, GAP=0, two bytes queued -> the second cell follows the first with no dec_en=0 cycle; char_done pulses twice, 4 cycles apart.
REQ-034 Raise pause for 5 cycles during SHOW with HOLD=3 -> the cell stays displayed 8 cycles total; bytes pushed during the pause are accepted.
REQ-035 Send 0xC1, then 0x42 -> err=1 and stays set; only 0x42 is displayed (dec_bits=6'b000010); fifo_count never counts 0xC1.
REQ-036 Drop rst_n asynchronously mid-SHOW with 2 bytes buffered -> all outputs clear immediately to their REQ-029 values; after release a new byte is displayed with the REQ-025 latency.

Source files
------------

// File: rtl/braille_sequencer.sv
// braille_sequencer: 4-entry character FIFO feeding a timed Braille cell display.
// Display outputs are registered one cycle behind the FSM, so a cell appears two edges after its accept.
module braille_sequencer #(
  parameter int unsigned HOLD_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES  = 10000,
  parameter int unsigned DEPTH       = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_char_i,
  input  logic       pause_i,
  output logic [5:0] dec_bits_o,
  output logic       dec_en_o,
  output logic       char_done_o,
  output logic       busy_o,
  output logic [2:0] fifo_count_o,
  output logic       err_o
);
  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  mem_q [4];
  logic [1:0]  wr_q, rd_q;
  logic [2:0]  count_q;
  logic [5:0]  cell_q, dec_bits_q;
  logic        dec_en_q, char_done_q, err_q;
  logic        accept, push, pop, done;
  assign in_ready_o   = count_q < 3'(DEPTH);
  assign accept       = in_valid_i && in_ready_o;
  assign push         = accept && !in_char_i[7];
  assign dec_bits_o   = dec_bits_q;
  assign dec_en_o     = dec_en_q;
  assign char_done_o  = char_done_q;
  assign fifo_count_o = count_q;
  assign err_o        = err_q;
  assign busy_o       = state_q != IDLE || count_q != 0 || dec_en_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (count_q != 0) begin
        pop     = 1'b1;
        state_d = SHOW;
        cnt_d   = '0;
      end
      SHOW: if (!pause_i) begin
        if (cnt_q == HOLD_LAST) begin
          done  = 1'b1;
          cnt_d = '0;
          if (GAP_CYCLES != 0) state_d = GAP;
          else if (count_q != 0) pop = 1'b1;
          else state_d = IDLE;
        end else cnt_d = cnt_q + 16'd1;
      end
      GAP: if (!pause_i) begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          pop     = count_q != 0;
          state_d = count_q != 0 ? SHOW : IDLE;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= in_char_i[5:0];
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      cell_q      <= '0;
      dec_bits_q  <= '0;
      dec_en_q    <= 1'b0;
      char_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_q + 2'(push);
      rd_q        <= rd_q + 2'(pop);
      count_q     <= count_q + 3'(push) - 3'(pop);
      if (pop) cell_q <= mem_q[rd_q];
      dec_en_q    <= state_q == SHOW;
      dec_bits_q  <= state_q == SHOW ? cell_q : '0;
      char_done_q <= done;
      err_q       <= err_q | (accept & in_char_i[7]);
    end
  end
endmodule
